ram_ctrl: RTL and testbench
===========================

RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 SHALL have parameter word_size, default 20, data word width in bits.
REQ-002 SHALL have parameter word_amount, default 30, number of RAM words; AW = $clog2(word_amount).
REQ-003 SHALL have parameter fifo_depth, default 4, request queue depth (power of two).
REQ-004 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req_valid in 1 / req_ready out 1, the request handshake.
REQ-007 SHALL have ports req_write in 1 (0=read, 1=write), req_addr in AW, req_wdata in word_size.
REQ-008 SHALL have ports rsp_valid out 1 / rsp_ready in 1, the response handshake.
REQ-009 SHALL have ports rsp_rdata out word_size, read data (0 for writes), and rsp_err out 1, address-out-of-range flag.
REQ-010 SHALL have RAM-side ports mem_address out AW, mem_select out 1, mem_operation out 1, mem_wdata out word_size, mem_rdata in word_size.
REQ-011 SHALL have port busy out 1, high when the FSM is not IDLE or the queue is non-empty.

Function
REQ-012 SHALL accept a request on a rising edge with req_valid & req_ready; req_ready = queue not full.
REQ-013 SHALL buffer accepted requests in a fifo_depth FIFO, in order; a simultaneous push and pop on a full queue SHALL NOT be allowed (req_ready low when full).
REQ-014 SHALL run FSM IDLE -> SETUP -> STROBE -> HOLD -> RESP -> IDLE, one cycle per state except RESP.
REQ-015 IDLE: pop the queue head when non-empty, latch it, go to SETUP; otherwise stay in IDLE.
REQ-016 SETUP: drive mem_address, mem_operation (READ=0, WRITE=1), mem_wdata from the latched request, mem_select=0.
REQ-017 STROBE: hold the bus, mem_select=1 for exactly one cycle (the RAM acts on the select rising edge).
REQ-018 HOLD: bus held, mem_select=0; for reads capture mem_rdata into rsp_rdata at the end of the cycle.
REQ-019 RESP: rsp_valid=1, outputs stable until rsp_ready; on rsp_valid & rsp_ready go to IDLE.
REQ-020 If req_addr >= word_amount: skip SETUP/STROBE/HOLD, go IDLE -> RESP with rsp_err=1, rsp_rdata=0, mem_select never asserted.
REQ-021 Every request SHALL produce exactly one response; write responses carry rsp_rdata=0, rsp_err=0.
REQ-022 Bus outputs SHALL change only in IDLE->SETUP transitions; mem_select SHALL be glitch-free (registered).
REQ-023 Best-case throughput SHALL be one request per 5 cycles (SETUP, STROBE, HOLD, RESP, IDLE) with rsp_ready tied high.
REQ-024 Requests arriving during RESP backpressure SHALL still be accepted while the queue has space.

Reset
REQ-025 While rst_n=0: FSM=IDLE, queue empty, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_select=0, mem_operation=0, mem_address=0, mem_wdata=0, busy=0.
REQ-026 req_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-027 Reset mid-operation SHALL drop the in-flight and queued requests with no response; mem_select SHALL drop immediately.

Structure
REQ-028 A shared package ram_pkg SHALL hold READ/WRITE constants, the FSM state enum and the request struct (write, addr, wdata).
REQ-029 The queue SHALL be a sub-module ram_cmd_fifo (parameterised width/depth, push/pop/full/empty).

Verification
REQ-030 After reset, write 0x12345 to addr 3, then read addr 3 -> two responses, second rsp_rdata=0x12345, rsp_err=0.
REQ-031 Read addr 30 (out of range) -> rsp_err=1, rsp_rdata=0, mem_select stays 0 throughout.
REQ-032 Hold rsp_ready=0, issue 6 back-to-back requests -> 1 in flight + 4 queued, req_ready low at the 6th; all 6 responses are returned in order after release.
REQ-033 Check each access -> mem_select high exactly one cycle, with address/operation/wdata stable from SETUP through HOLD.
REQ-034 Assert rst_n=0 during STROBE of a write -> mem_select falls immediately, no response is issued, busy=0, and a later read of that address returns the pre-reset value.
REQ-035 Writes to addr 0 and addr 29 with distinct data, then read both -> correct data at both boundary addresses.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants and types for the RAM bus controller: operation codes,
// FSM state encoding and the request record carried through the command queue.
package ram_pkg;

    localparam logic RamRead  = 1'b0;
    localparam logic RamWrite = 1'b1;

    // Widest address/data a request record can carry; narrower instances zero-extend.
    localparam int unsigned ReqAddrMax = 32;
    localparam int unsigned ReqDataMax = 64;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StResp
    } ram_state_e;

    typedef struct packed {
        logic                  write;
        logic [ReqAddrMax-1:0] addr;
        logic [ReqDataMax-1:0] wdata;
    } ram_req_t;

endpackage

// File: rtl/ram_cmd_fifo.sv
// In-order request queue for ram_ctrl. Depth must be a power of two (>= 2);
// pointers carry one wrap bit to tell full from empty.
module ram_cmd_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
    logic             push_en, pop_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[PtrW-1:0]];

    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) wr_ptr_d = wr_ptr_q + (PtrW+1)'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + (PtrW+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/ram_ctrl.sv
// Queued request/response front end for an asynchronous select-strobed RAM.
// Each access runs SETUP -> STROBE -> HOLD -> RESP with all bus outputs registered.
module ram_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned word_size   = 20,
    parameter int unsigned word_amount = 30,
    parameter int unsigned fifo_depth  = 4,
    localparam int unsigned AW = (word_amount > 1) ? $clog2(word_amount) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [AW-1:0]        req_addr,
    input  logic [word_size-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [word_size-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [AW-1:0]        mem_address,
    output logic                 mem_select,
    output logic                 mem_operation,
    output logic [word_size-1:0] mem_wdata,
    input  logic [word_size-1:0] mem_rdata,
    output logic                 busy
);

    localparam int unsigned EntryW = 1 + AW + word_size;

    ram_state_e           state_q, state_d;
    logic [EntryW-1:0]    fifo_rdata;
    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
    ram_req_t             head;
    logic                 head_oor;
    logic                 unused_head_wdata;
    logic                 ready_q;
    logic [AW-1:0]        mem_address_q;
    logic                 mem_operation_q;
    logic [word_size-1:0] mem_wdata_q;
    logic                 mem_select_q;
    logic [word_size-1:0] rsp_rdata_q;
    logic                 rsp_err_q;

    assign fifo_push = req_valid && req_ready;
    assign fifo_pop  = (state_q == StIdle) && !fifo_empty;

    ram_cmd_fifo #(
        .Width (EntryW),
        .Depth (fifo_depth)
    ) u_cmd_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (fifo_push),
        .wdata_i ({req_write, req_addr, req_wdata}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        head       = '0;
        head.write = fifo_rdata[EntryW-1];
        head.addr  = ReqAddrMax'(fifo_rdata[word_size +: AW]);
        head.wdata = ReqDataMax'(fifo_rdata[word_size-1:0]);
    end

    // Compared at full record width so AW-bit codes past the last word are caught.
    assign head_oor          = (head.addr >= ReqAddrMax'(word_amount));
    assign unused_head_wdata = ^head.wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (!fifo_empty) state_d = head_oor ? StResp : StSetup;
            StSetup:  state_d = StStrobe;
            StStrobe: state_d = StHold;
            StHold:   state_d = StResp;
            StResp:   if (rsp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q         <= 1'b0;
            mem_address_q   <= '0;
            mem_operation_q <= RamRead;
            mem_wdata_q     <= '0;
            mem_select_q    <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= 1'b0;
        end else begin
            ready_q      <= 1'b1;
            mem_select_q <= (state_d == StStrobe);
            if (fifo_pop) begin
                rsp_rdata_q <= '0;
                rsp_err_q   <= head_oor;
                // Out-of-range requests never touch the bus.
                if (!head_oor) begin
                    mem_address_q   <= head.addr[AW-1:0];
                    mem_operation_q <= head.write;
                    mem_wdata_q     <= head.wdata[word_size-1:0];
                end
            end
            if (state_q == StHold && mem_operation_q == RamRead) rsp_rdata_q <= mem_rdata;
        end
    end

    always_comb begin
        req_ready     = ready_q && !fifo_full;
        rsp_valid     = (state_q == StResp);
        rsp_rdata     = rsp_rdata_q;
        rsp_err       = rsp_err_q;
        mem_address   = mem_address_q;
        mem_select    = mem_select_q;
        mem_operation = mem_operation_q;
        mem_wdata     = mem_wdata_q;
        busy          = (state_q != StIdle) || !fifo_empty;
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed and randomized bench for ram_ctrl with a behavioural RAM and a
// queue/array reference model of request ordering and memory contents.
module tb_ram_ctrl;

    localparam int unsigned WS = 20;
    localparam int unsigned WA = 30;
    localparam int unsigned FD = 4;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [WS-1:0] req_wdata = '0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [WS-1:0] rsp_rdata;
    logic [AW-1:0] mem_address;
    logic          mem_select, mem_operation, busy;
    logic [WS-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    ram_ctrl #(
        .word_size   (WS),
        .word_amount (WA),
        .fifo_depth  (FD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .mem_address   (mem_address),
        .mem_select    (mem_select),
        .mem_operation (mem_operation),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .busy          (busy)
    );

    // Behavioural RAM: acts on the rising edge of select.
    logic [WS-1:0] ram [32];
    logic [WS-1:0] ram_rdata;
    assign mem_rdata = ram_rdata;
    always @(posedge mem_select) begin
        if (mem_operation) ram[mem_address] <= mem_wdata;
        else               ram_rdata <= ram[mem_address];
    end

    typedef struct {
        logic [WS-1:0] rdata;
        logic          err;
    } rsp_t;

    int               checks = 0;
    int               errors = 0;
    int               rsp_count = 0;
    int               exp_strobes = 0;
    int               obs_strobes = 0;
    bit               accepted;
    bit               rand_ready = 0;
    logic [WS-1:0]    ref_mem [WA];
    rsp_t             exp_q [$];
    logic [AW+WS:0]   bus_q [$];
    logic [WS-1:0]    last_rdata;
    logic             last_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input bit w, input int a, input logic [WS-1:0] d);
        rsp_t r;
        r.err   = (a >= WA);
        r.rdata = '0;
        if (!r.err) begin
            if (w) ref_mem[a] = d;
            else   r.rdata = ref_mem[a];
            bus_q.push_back({a[AW-1:0], w, d});
            exp_strobes++;
        end
        exp_q.push_back(r);
    endtask

    // One clock: check any offered response, then advance to 1ns after the edge.
    task automatic step();
        bit acc, got;
        acc = req_valid && req_ready;
        got = rsp_valid && rsp_ready;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
            end else begin
                check(got ? "rsp_rdata" : "rsp_hold_rdata", 64'(rsp_rdata), 64'(exp_q[0].rdata));
                check(got ? "rsp_err" : "rsp_hold_err", 64'(rsp_err), 64'(exp_q[0].err));
                if (got) begin
                    last_rdata = rsp_rdata;
                    last_err   = rsp_err;
                    exp_q.delete(0);
                    rsp_count++;
                end
            end
        end
        @(posedge clk);
        #1;
        if (acc) begin
            model_accept(req_write, int'(req_addr), req_wdata);
            req_valid = 1'b0;
            accepted  = 1'b1;
        end
        if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input bit w, input logic [AW-1:0] a, input logic [WS-1:0] d);
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        accepted  = 1'b0;
        for (int i = 0; i < 200 && !accepted; i++) step();
        if (!accepted) begin
            check("issue_timeout", {63'd0, accepted}, 64'd1);
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        rand_ready = 0;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) step();
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    // Bus monitor: select is one sample wide and the bus is steady SETUP..HOLD.
    logic           sel_h1 = 1'b0;
    logic [AW+WS:0] bus_h1 = '0, bus_h2 = '0;
    always @(posedge mem_select) obs_strobes++;
    always @(negedge clk) begin
        if (sel_h1) begin
            check("strobe_width", {63'd0, mem_select}, 64'd0);
            check("bus_setup_stable", 64'(bus_h2), 64'(bus_h1));
            check("bus_hold_stable", 64'({mem_address, mem_operation, mem_wdata}), 64'(bus_h1));
            if (bus_q.size() == 0) begin
                check("strobe_unexpected", {63'd0, sel_h1}, 64'd0);
            end else begin
                check("strobe_bus", 64'(bus_h1), 64'(bus_q[0]));
                bus_q.delete(0);
            end
        end
        sel_h1 <= mem_select;
        bus_h2 <= bus_h1;
        bus_h1 <= {mem_address, mem_operation, mem_wdata};
    end

    initial begin
        int            n, s0, c0, a;
        logic [WS-1:0] d, dnew;

        for (int i = 0; i < 32; i++) ram[i] = '0;
        for (int i = 0; i < int'(WA); i++) ref_mem[i] = '0;
        ram_rdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {63'd0, req_ready}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        check("rst_mem_select", {63'd0, mem_select}, 64'd0);
        check("rst_mem_operation", {63'd0, mem_operation}, 64'd0);
        check("rst_mem_address", 64'(mem_address), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;
        check("ready_before_edge", {63'd0, req_ready}, 64'd0);
        step();
        check("ready_after_edge", {63'd0, req_ready}, 64'd1);

        // Write then read back address 3
        rsp_ready = 1'b1;
        issue(1'b1, 5'd3, 20'h12345);
        drain();
        issue(1'b0, 5'd3, '0);
        drain();
        check("wr_rd_addr3_data", 64'(last_rdata), 64'h12345);
        check("wr_rd_addr3_err", {63'd0, last_err}, 64'd0);

        // Accept-to-response latency: pop, SETUP, STROBE, HOLD, then RESP visible
        rsp_ready = 1'b0;
        issue(1'b0, 5'd3, '0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check("resp_latency", 64'(n), 64'd4);
        drain();

        // Out-of-range read and write never strobe the RAM
        s0 = obs_strobes;
        issue(1'b0, 5'd30, '0);
        drain();
        check("oor_rd_err", {63'd0, last_err}, 64'd1);
        check("oor_rd_data", 64'(last_rdata), 64'd0);
        issue(1'b1, 5'd31, 20'($urandom));
        drain();
        check("oor_wr_err", {63'd0, last_err}, 64'd1);
        check("oor_no_strobe", 64'(obs_strobes - s0), 64'd0);

        // Boundary addresses
        issue(1'b1, 5'd0, 20'hABCDE);
        issue(1'b1, 5'd29, 20'h5A5A5);
        issue(1'b0, 5'd0, '0);
        issue(1'b0, 5'd29, '0);
        drain();
        check("addr29_data", 64'(last_rdata), 64'h5A5A5);

        // Backpressure: 1 in flight + 4 queued, 6th request stalls
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, WA - 1)), 20'($urandom));
        req_write = 1'b0;
        req_addr  = 5'd29;
        req_valid = 1'b1;
        accepted  = 1'b0;
        check("full_ready_low", {63'd0, req_ready}, 64'd0);
        repeat (3) step();
        check("full_ready_still_low", {63'd0, req_ready}, 64'd0);
        check("full_busy", {63'd0, busy}, 64'd1);
        check("full_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        rsp_ready = 1'b1;
        c0 = rsp_count;
        for (int i = 0; i < 200 && !(accepted && exp_q.size() == 0); i++) step();
        check("backpressure_rsp_count", 64'(rsp_count - c0), 64'd6);

        // Randomized traffic with random response backpressure
        rand_ready = 1;
        for (int i = 0; i < 24; i++)
            issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 20'($urandom));
        drain();

        // Reset during STROBE of a write
        a    = $urandom_range(1, WA - 2);
        d    = ref_mem[a];
        dnew = d ^ 20'hF0F0F;
        issue(1'b1, 5'(a), dnew);
        step();
        step();
        check("strobe_before_reset", {63'd0, mem_select}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("reset_drops_select", {63'd0, mem_select}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset_req_ready", {63'd0, req_ready}, 64'd0);
        exp_q.delete();
        bus_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        c0 = rsp_count;
        repeat (8) step();
        check("reset_no_response", 64'(rsp_count - c0), 64'd0);
        // Select had already risen, so the RAM holds the interrupted write's data.
        issue(1'b0, 5'(a), '0);
        drain();
        check("post_reset_read", 64'(last_rdata), 64'(dnew));

        check("strobe_count", 64'(obs_strobes), 64'(exp_strobes));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
